// File: rtl/wb_pkg.sv
// Shared definitions for the writeback commit stage: control-bus bit map,
// load-extract select encodings and the halt/resume state encoding.
package wb_pkg;

  localparam int CTL_REGWRITE = 0;
  localparam int CTL_MEMTOREG = 1;
  localparam int CTL_HIWRITE  = 2;
  localparam int CTL_LOWRITE  = 3;
  localparam int CTL_HILO64   = 4;
  localparam int CTL_CP0WRITE = 5;
  localparam int CTL_HALT     = 6;
  localparam int CTL_VALID    = 7;

  localparam logic [2:0] SEL_LW  = 3'd0;
  localparam logic [2:0] SEL_LB  = 3'd1;
  localparam logic [2:0] SEL_LBU = 3'd2;
  localparam logic [2:0] SEL_LH  = 3'd3;
  localparam logic [2:0] SEL_LHU = 3'd4;

  typedef enum logic [0:0] {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_load_extract.sv
// Little-endian byte/halfword extraction from a raw memory read word.
// Unlisted select codes fall back to the full word; addr[0] is ignored for halfwords.
module wb_load_extract
  import wb_pkg::*;
(
  input  logic [2:0]  sel_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (sel_i)
      SEL_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      SEL_LBU: data_o = {24'h000000, byte_sel};
      SEL_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      SEL_LHU: data_o = {16'h0000, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit stage: GPR/CP0/HI-LO write ports, retire counter, halt/resume FSM.
// Optional WB_HILO_BYPASS_EN adds hi_rd/lo_rd showing post-commit HI/LO combinationally.
//
// state  | meaning
// RUN    | instructions commit, adv=1
// HALTED | inputs ignored, adv=0 until resume
module wb_commit
  import wb_pkg::*;
#(
  parameter int CTRL_W = 34,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rset,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [4:0]        reg_w_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       alu2_in,
  input  logic [31:0]       data_in,
  input  logic [31:0]       pc_in,
  input  logic [2:0]        sel_in,
  input  logic [63:0]       hilo_in,
  input  logic [31:0]       cp0_data_in,
  input  logic [4:0]        cp0_reg_in,
  input  logic              resume,
  output logic              adv,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              cp0_we,
  output logic [4:0]        cp0_waddr,
  output logic [31:0]       cp0_wdata,
  output logic [31:0]       hi,
  output logic [31:0]       lo,
`ifdef WB_HILO_BYPASS_EN
  output logic [31:0]       hi_rd,
  output logic [31:0]       lo_rd,
`endif
  output logic [CNT_W-1:0]  retired,
  output logic              halted,
  output logic [31:0]       last_pc
);

  localparam logic [0:0] S_RUN    = WB_RUN;
  localparam logic [0:0] S_HALTED = WB_HALTED;

  logic [0:0]       state_q, state_d;
  logic             adv_q;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic             cp0_we_q, cp0_we_d;
  logic [4:0]       cp0_waddr_q;
  logic [31:0]      cp0_wdata_q;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] retired_q;
  logic [31:0]      last_pc_q;
  logic [31:0]      load_data;
  logic             commit;

  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_in[CTRL_W-1:8];

  wb_load_extract u_extract (
    .sel_i  (sel_in),
    .addr_i (alu_in[1:0]),
    .word_i (data_in),
    .data_o (load_data)
  );

  assign commit = ctrl_in[CTL_VALID] & (state_q == S_RUN);

  always_comb begin
    rf_we_d    = commit & ctrl_in[CTL_REGWRITE] & (reg_w_in != 5'd0);
    rf_wdata_d = ctrl_in[CTL_MEMTOREG] ? load_data : alu_in;
    cp0_we_d   = commit & ctrl_in[CTL_CP0WRITE];
  end

  // A 64-bit MULT/DIV result takes precedence over single MTHI/MTLO writes.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      if (ctrl_in[CTL_HILO64]) begin
        hi_d = hilo_in[63:32];
        lo_d = hilo_in[31:0];
      end else begin
        if (ctrl_in[CTL_HIWRITE]) hi_d = alu2_in;
        if (ctrl_in[CTL_LOWRITE]) lo_d = alu2_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (commit && ctrl_in[CTL_HALT]) state_d = S_HALTED;
      S_HALTED: if (resume) state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      state_q     <= S_RUN;
      adv_q       <= 1'b1;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'd0;
      cp0_we_q    <= 1'b0;
      cp0_waddr_q <= 5'd0;
      cp0_wdata_q <= 32'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      retired_q   <= '0;
      last_pc_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      adv_q    <= (state_d == S_RUN);
      rf_we_q  <= rf_we_d;
      cp0_we_q <= cp0_we_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      if (rf_we_d) begin
        rf_waddr_q <= reg_w_in;
        rf_wdata_q <= rf_wdata_d;
      end
      if (cp0_we_d) begin
        cp0_waddr_q <= cp0_reg_in;
        cp0_wdata_q <= cp0_data_in;
      end
      if (commit) begin
        retired_q <= retired_q + 1'b1;
        last_pc_q <= pc_in;
      end
    end
  end

  assign adv       = adv_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign cp0_we    = cp0_we_q;
  assign cp0_waddr = cp0_waddr_q;
  assign cp0_wdata = cp0_wdata_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign retired   = retired_q;
  assign halted    = (state_q == S_HALTED);
  assign last_pc   = last_pc_q;

`ifdef WB_HILO_BYPASS_EN
  assign hi_rd = hi_d;
  assign lo_rd = lo_d;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit; a narrow retire counter keeps the wrap case short.
module tb_wb_commit;

  localparam int CTRL_W = 34;
  localparam int CNT_W  = 8;

  localparam logic [CTRL_W-1:0] C_RW   = 34'h001;
  localparam logic [CTRL_W-1:0] C_M2R  = 34'h002;
  localparam logic [CTRL_W-1:0] C_HIW  = 34'h004;
  localparam logic [CTRL_W-1:0] C_LOW  = 34'h008;
  localparam logic [CTRL_W-1:0] C_H64  = 34'h010;
  localparam logic [CTRL_W-1:0] C_CP0  = 34'h020;
  localparam logic [CTRL_W-1:0] C_HALT = 34'h040;
  localparam logic [CTRL_W-1:0] C_V    = 34'h080;

  logic              clk = 1'b0;
  logic              rset;
  logic [CTRL_W-1:0] ctrl_in;
  logic [4:0]        reg_w_in;
  logic [31:0]       alu_in, alu2_in, data_in, pc_in;
  logic [2:0]        sel_in;
  logic [63:0]       hilo_in;
  logic [31:0]       cp0_data_in;
  logic [4:0]        cp0_reg_in;
  logic              resume;
  logic              adv, rf_we, cp0_we, halted;
  logic [4:0]        rf_waddr, cp0_waddr;
  logic [31:0]       rf_wdata, cp0_wdata, hi, lo, last_pc;
  logic [CNT_W-1:0]  retired;

  int vectors = 0;
  int miscompares = 0;
  logic [CNT_W-1:0] exp_ret;

  wb_commit #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rset(rset), .ctrl_in(ctrl_in), .reg_w_in(reg_w_in),
    .alu_in(alu_in), .alu2_in(alu2_in), .data_in(data_in), .pc_in(pc_in),
    .sel_in(sel_in), .hilo_in(hilo_in), .cp0_data_in(cp0_data_in),
    .cp0_reg_in(cp0_reg_in), .resume(resume), .adv(adv), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cp0_we(cp0_we),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .hi(hi), .lo(lo),
    .retired(retired), .halted(halted), .last_pc(last_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input string tag, input logic [2:0] sel, input logic [1:0] a,
                          input logic [31:0] exp);
    ctrl_in  = C_V | C_RW | C_M2R;
    reg_w_in = 5'd3;
    sel_in   = sel;
    alu_in   = {30'h0, a};
    step();
    exp_ret++;
    check({tag, "_we"}, {63'h0, rf_we}, 64'h1);
    check(tag, {32'h0, rf_wdata}, {32'h0, exp});
  endtask

  initial begin
    rset = 1'b1; ctrl_in = '0; reg_w_in = 5'd0; alu_in = 32'h0; alu2_in = 32'h0;
    data_in = 32'h0; pc_in = 32'h0; sel_in = 3'd0; hilo_in = 64'h0;
    cp0_data_in = 32'h0; cp0_reg_in = 5'd0; resume = 1'b0; exp_ret = '0;
    step(); step();
    rset = 1'b0;
    step();
    check("rst_adv", {63'h0, adv}, 64'h1);
    check("rst_rf_we", {63'h0, rf_we}, 64'h0);
    check("rst_halted", {63'h0, halted}, 64'h0);
    check("rst_retired", {56'h0, retired}, 64'h0);

    // loads
    data_in = 32'h80F1_7F22;
    pc_in   = 32'h0000_0100;
    load_vec("lb_a1", 3'd1, 2'd1, 32'h0000_007F);
    load_vec("lb_a2", 3'd1, 2'd2, 32'hFFFF_FFF1);
    load_vec("lbu_a3", 3'd2, 2'd3, 32'h0000_0080);
    load_vec("lh_a2", 3'd3, 2'd2, 32'hFFFF_80F1);
    load_vec("lhu_a0", 3'd4, 2'd0, 32'h0000_7F22);
    load_vec("lhu_a3", 3'd4, 2'd3, 32'h0000_80F1);
    load_vec("lw", 3'd0, 2'd1, 32'h80F1_7F22);
    load_vec("sel7", 3'd7, 2'd2, 32'h80F1_7F22);
    check("ret_loads", {56'h0, retired}, {56'h0, exp_ret});
    check("last_pc", {32'h0, last_pc}, 64'h100);

    // $0 guard
    ctrl_in = C_V | C_RW; reg_w_in = 5'd0; alu_in = 32'h0000_9999;
    step(); exp_ret++;
    check("r0_we", {63'h0, rf_we}, 64'h0);
    reg_w_in = 5'd8; alu_in = 32'h0000_1234; pc_in = 32'h0000_0200;
    step(); exp_ret++;
    check("r8_we", {63'h0, rf_we}, 64'h1);
    check("r8_waddr", {59'h0, rf_waddr}, 64'h8);
    check("r8_wdata", {32'h0, rf_wdata}, 64'h1234);
    ctrl_in = '0;
    step();
    check("we_pulse", {63'h0, rf_we}, 64'h0);
    check("ret_after_r0", {56'h0, retired}, {56'h0, exp_ret});

    // HI/LO
    ctrl_in = C_V | C_H64; hilo_in = 64'hAAAA_BBBB_CCCC_DDDD;
    step(); exp_ret++;
    check("h64_hi", {32'h0, hi}, 64'hAAAA_BBBB);
    check("h64_lo", {32'h0, lo}, 64'hCCCC_DDDD);
    ctrl_in = C_V | C_HIW; alu2_in = 32'h5;
    step(); exp_ret++;
    check("hiw_hi", {32'h0, hi}, 64'h5);
    check("hiw_lo", {32'h0, lo}, 64'hCCCC_DDDD);
    ctrl_in = C_V | C_HIW | C_LOW; alu2_in = 32'h7;
    step(); exp_ret++;
    check("both_hi", {32'h0, hi}, 64'h7);
    check("both_lo", {32'h0, lo}, 64'h7);
    ctrl_in = C_V | C_H64 | C_HIW; hilo_in = 64'h1111_2222_3333_4444; alu2_in = 32'h9;
    step(); exp_ret++;
    check("win_hi", {32'h0, hi}, 64'h1111_2222);
    check("win_lo", {32'h0, lo}, 64'h3333_4444);
    ctrl_in = C_HIW; alu2_in = 32'hBAD0;
    step();
    check("nonvalid_hi", {32'h0, hi}, 64'h1111_2222);

    // CP0
    ctrl_in = C_V | C_CP0; cp0_reg_in = 5'd12; cp0_data_in = 32'hDEAD_BEEF;
    step(); exp_ret++;
    check("cp0_we", {63'h0, cp0_we}, 64'h1);
    check("cp0_waddr", {59'h0, cp0_waddr}, 64'hC);
    check("cp0_wdata", {32'h0, cp0_wdata}, 64'hDEAD_BEEF);
    check("cp0_rf_we", {63'h0, rf_we}, 64'h0);
    ctrl_in = '0;
    step();
    check("cp0_pulse", {63'h0, cp0_we}, 64'h0);

    // halt with a simultaneous resume: halt wins
    ctrl_in = C_V | C_RW | C_HALT; reg_w_in = 5'd5; alu_in = 32'h55;
    pc_in = 32'h0000_0300; resume = 1'b1;
    step(); exp_ret++;
    resume = 1'b0;
    check("halt_rf_we", {63'h0, rf_we}, 64'h1);
    check("halt_wdata", {32'h0, rf_wdata}, 64'h55);
    check("halt_ret", {56'h0, retired}, {56'h0, exp_ret});
    check("halt_halted", {63'h0, halted}, 64'h1);
    check("halt_adv", {63'h0, adv}, 64'h0);
    check("halt_pc", {32'h0, last_pc}, 64'h300);
    ctrl_in = C_V | C_RW | C_HIW; reg_w_in = 5'd9; alu2_in = 32'h77; pc_in = 32'h400;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hlt_rf_we", {63'h0, rf_we}, 64'h0);
      check("hlt_adv", {63'h0, adv}, 64'h0);
    end
    check("hlt_ret", {56'h0, retired}, {56'h0, exp_ret});
    check("hlt_hi", {32'h0, hi}, 64'h1111_2222);
    check("hlt_pc", {32'h0, last_pc}, 64'h300);
    ctrl_in = '0; resume = 1'b1;
    step();
    resume = 1'b0;
    check("res_adv", {63'h0, adv}, 64'h1);
    check("res_halted", {63'h0, halted}, 64'h0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("res_in_run", {63'h0, halted}, 64'h0);

    // asynchronous reset mid-run
    ctrl_in = C_V | C_RW; reg_w_in = 5'd4; alu_in = 32'h44;
    step(); exp_ret++;
    check("pre_rst_ret", {56'h0, retired}, {56'h0, exp_ret});
    #2 rset = 1'b1;
    #1;
    check("arst_rf_we", {63'h0, rf_we}, 64'h0);
    check("arst_hi", {32'h0, hi}, 64'h0);
    check("arst_lo", {32'h0, lo}, 64'h0);
    check("arst_ret", {56'h0, retired}, 64'h0);
    check("arst_adv", {63'h0, adv}, 64'h1);
    check("arst_pc", {32'h0, last_pc}, 64'h0);
    check("arst_cp0", {32'h0, cp0_wdata}, 64'h0);
    ctrl_in = '0;
    step();
    rset = 1'b0;
    exp_ret = '0;

    // counter wrap
    ctrl_in = C_V;
    for (int i = 0; i < 255; i++) begin
      step(); exp_ret++;
    end
    check("wrap_max", {56'h0, retired}, 64'hFF);
    step(); exp_ret++;
    check("wrap_zero", {56'h0, retired}, {56'h0, exp_ret});
    check("wrap_zero_abs", {56'h0, retired}, 64'h0);
    ctrl_in = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
